// File: rtl/fetch_prefetch.sv
// fetch_prefetch: byte-serial instruction fetch with word assembly and a
// small first-word-fall-through prefetch queue toward decode.
// Bytes are requested sequentially from code memory. Each word is packed
// MSB-first and pushed with the address of its first byte. A redirect
// flushes everything and restarts fetching at redirect_pc.
module fetch_prefetch #(
   parameter int unsigned       ADDR_W      = 8,
   parameter int unsigned       INSTR_BYTES = 4,
   parameter int unsigned       FIFO_DEPTH  = 2,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cs_fetch,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     mem_req,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_rdy,
   input  logic [7:0]               mem_data,
   output logic [8*INSTR_BYTES-1:0] instr,
   output logic [ADDR_W-1:0]        instr_pc,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic                     rdy_fetch
);

   localparam int unsigned IW    = 8 * INSTR_BYTES;
   localparam int unsigned BC_W  = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(INSTR_BYTES - 1);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [OCC_W-1:0] FULL_CNT  = OCC_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [IW-1:0]     partial_q, partial_d;
   logic [ADDR_W-1:0] word_pc_q, word_pc_d;

   logic [IW-1:0]     fifo_data_q [FIFO_DEPTH];
   logic [IW-1:0]     fifo_data_d [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_pc_d   [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;

   logic              pop;
   logic              push;
   logic [OCC_W-1:0]  occ_left;
   logic [IW-1:0]     assembled;
   logic [ADDR_W-1:0] push_pc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Assembler FSM, word packing and queue bookkeeping; redirect overrides everything.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      byte_cnt_d  = byte_cnt_q;
      partial_d   = partial_q;
      word_pc_d   = word_pc_q;
      fifo_data_d = fifo_data_q;
      fifo_pc_d   = fifo_pc_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      occ_d       = occ_q;
      pop         = 1'b0;
      push        = 1'b0;
      push_pc     = (byte_cnt_q == '0) ? pc_q : word_pc_q;

      assembled = partial_q;
      for (int unsigned i = 0; i < INSTR_BYTES; i++) begin
         if (byte_cnt_q == BC_W'(i)) begin
            assembled[IW-1-8*i -: 8] = mem_data;
         end
      end

      if (!redirect) begin
         pop = (occ_q != '0) && instr_ready;
      end
      occ_left = occ_q - OCC_W'(pop);

      if (redirect) begin
         pc_d       = redirect_pc;
         byte_cnt_d = '0;
         partial_d  = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         occ_d      = '0;
         state_d    = cs_fetch ? S_REQ : S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (cs_fetch) begin
                  state_d = (occ_left == FULL_CNT) ? S_HOLD : S_REQ;
               end
            end
            S_REQ: begin
               if (mem_rdy) begin
                  pc_d = pc_q + ADDR_W'(1);
                  if (byte_cnt_q == '0) begin
                     word_pc_d = pc_q;
                  end
                  if (byte_cnt_q == LAST_BYTE) begin
                     push       = 1'b1;
                     byte_cnt_d = '0;
                     partial_d  = '0;
                     if (!cs_fetch) begin
                        state_d = S_IDLE;
                     end else if (occ_left == FULL_CNT - OCC_W'(1)) begin
                        state_d = S_HOLD;
                     end
                  end else begin
                     byte_cnt_d = byte_cnt_q + BC_W'(1);
                     partial_d  = assembled;
                     // Never request a last byte that would have nowhere to go.
                     if ((byte_cnt_d == LAST_BYTE) && (occ_left == FULL_CNT)) begin
                        state_d = S_HOLD;
                     end
                  end
               end
            end
            S_HOLD: begin
               if ((byte_cnt_q == '0) && !cs_fetch) begin
                  state_d = S_IDLE;
               end else if (occ_left != FULL_CNT) begin
                  state_d = S_REQ;
               end
            end
            default: state_d = S_IDLE;
         endcase

         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (push) begin
            fifo_data_d[wr_ptr_q] = assembled;
            fifo_pc_d[wr_ptr_q]   = push_pc;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
         end
         occ_d = occ_left + OCC_W'(push);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         byte_cnt_q <= '0;
         partial_q  <= '0;
         word_pc_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         occ_q      <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_pc_q[i]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         byte_cnt_q  <= byte_cnt_d;
         partial_q   <= partial_d;
         word_pc_q   <= word_pc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         occ_q       <= occ_d;
         fifo_data_q <= fifo_data_d;
         fifo_pc_q   <= fifo_pc_d;
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      mem_req     = (state_q == S_REQ);
      mem_addr    = pc_q;
      rdy_fetch   = (state_q == S_IDLE);
      instr_valid = (occ_q != '0);
      instr       = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
      instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;
   end

endmodule
